// File: rtl/oq_pkt_store_ctrl.sv
// Output-queue packet store controller: pops one descriptor per packet, reserves
// space in the destination queue's memory region, then streams or drops the packet.
module oq_occ_lane #(
  parameter int OCC_W = 10,
  parameter int AW    = 9,
  parameter int LW    = 8,
  parameter int CW    = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [LW-1:0]    add_len,
  input  logic [LW-1:0]    sub_len,
  input  logic [LW-1:0]    rel_len,
  input  logic             ptr_inc,
  output logic [OCC_W-1:0] occ,
  output logic [AW-1:0]    wr_ptr
);
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [AW-1:0]    ptr_q, ptr_d;

  always_comb begin
    occ_d = OCC_W'(CW'(occ_q) + CW'(add_len) - CW'(sub_len) - CW'(rel_len));
    ptr_d = ptr_q + AW'(ptr_inc);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
      ptr_q <= '0;
    end else begin
      occ_q <= occ_d;
      ptr_q <= ptr_d;
    end
  end

  assign occ    = occ_q;
  assign wr_ptr = ptr_q;
endmodule

module oq_pkt_store_ctrl #(
  parameter int DATA_WIDTH         = 64,
  parameter int CTRL_WIDTH         = DATA_WIDTH/8,
  parameter int NUM_OUTPUT_QUEUES  = 8,
  parameter int NUM_OQ_WIDTH       = 3,
  parameter int PKT_WORD_CNT_WIDTH = 8,
  parameter int OQ_ADDR_WIDTH      = 9
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                dst_oq_avail,
  output logic                                rd_dst_oq,
  input  logic [NUM_OQ_WIDTH-1:0]             parsed_dst_oq,
  input  logic [PKT_WORD_CNT_WIDTH-1:0]       parsed_pkt_word_len,
  input  logic                                pkt_fifo_empty,
  output logic                                pkt_fifo_rd_en,
  input  logic [CTRL_WIDTH-1:0]               pkt_fifo_ctrl,
  input  logic [DATA_WIDTH-1:0]               pkt_fifo_data,
  output logic                                mem_wr_en,
  output logic [NUM_OQ_WIDTH+OQ_ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [CTRL_WIDTH+DATA_WIDTH-1:0]    mem_wr_data,
  input  logic                                rem_valid,
  input  logic [NUM_OQ_WIDTH-1:0]             rem_oq,
  input  logic [PKT_WORD_CNT_WIDTH-1:0]       rem_word_len,
  output logic                                pkt_stored,
  output logic                                pkt_dropped,
  output logic                                len_err,
  output logic [NUM_OQ_WIDTH-1:0]             stored_oq
);
  localparam int QW = OQ_ADDR_WIDTH + 1;
  localparam int LW = PKT_WORD_CNT_WIDTH;
  localparam int CW = (LW > QW) ? LW : QW;
  localparam int AW = NUM_OQ_WIDTH + OQ_ADDR_WIDTH;
  localparam int DW = CTRL_WIDTH + DATA_WIDTH;
  localparam logic [QW-1:0] REGION = QW'(1) << OQ_ADDR_WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HDR   = 2'd1;
  localparam logic [1:0] STORE = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [NUM_OQ_WIDTH-1:0] oq_q, oq_d, stored_oq_q, stored_oq_d;
  logic [LW-1:0]           len_q, len_d, cnt_q, cnt_d;
  logic                    store_q, store_d;
  logic                    mem_wr_en_q, mem_wr_en_d;
  logic [AW-1:0]           mem_wr_addr_q, mem_wr_addr_d;
  logic [DW-1:0]           mem_wr_data_q, mem_wr_data_d;
  logic                    pkt_stored_q, pkt_stored_d;
  logic                    pkt_dropped_q, pkt_dropped_d;
  logic                    len_err_q, len_err_d;

  logic [NUM_OUTPUT_QUEUES-1:0][QW-1:0]            occ_all;
  logic [NUM_OUTPUT_QUEUES-1:0][OQ_ADDR_WIDTH-1:0] ptr_all;

  logic          store_dec, rsv, wr_word;
  logic [LW-1:0] release_len;

  assign store_dec = (parsed_pkt_word_len != '0) &&
                     (CW'(parsed_pkt_word_len) <= CW'(REGION - occ_all[parsed_dst_oq]));

  always_comb begin
    state_d       = state_q;
    oq_d          = oq_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    store_d       = store_q;
    stored_oq_d   = stored_oq_q;
    mem_wr_en_d   = 1'b0;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    pkt_stored_d  = 1'b0;
    pkt_dropped_d = 1'b0;
    len_err_d     = 1'b0;
    rd_dst_oq     = 1'b0;
    pkt_fifo_rd_en = 1'b0;
    rsv           = 1'b0;
    wr_word       = 1'b0;
    release_len   = '0;
    case (state_q)
      IDLE: if (dst_oq_avail) begin
        rd_dst_oq = 1'b1;
        oq_d      = parsed_dst_oq;
        len_d     = parsed_pkt_word_len;
        store_d   = store_dec;
        rsv       = store_dec;
        cnt_d     = '0;
        state_d   = HDR;
      end
      HDR: begin
        pkt_fifo_rd_en = !pkt_fifo_empty;
        if (!pkt_fifo_empty && pkt_fifo_ctrl == '0) begin
          if (store_q) begin
            wr_word = 1'b1;
            cnt_d   = LW'(1);
            state_d = STORE;
          end else begin
            state_d = DROP;
          end
        end
      end
      STORE: begin
        pkt_fifo_rd_en = !pkt_fifo_empty;
        if (!pkt_fifo_empty) begin
          // Words beyond the reserved length are consumed but never written.
          if (cnt_q < len_q) begin
            wr_word = 1'b1;
            cnt_d   = cnt_q + LW'(1);
          end
          if (pkt_fifo_ctrl != '0) begin
            pkt_stored_d = 1'b1;
            stored_oq_d  = oq_q;
            state_d      = IDLE;
            if (cnt_q < len_q) begin
              if (cnt_q + LW'(1) != len_q) begin
                len_err_d   = 1'b1;
                release_len = len_q - cnt_q - LW'(1);
              end
            end else begin
              len_err_d = 1'b1;
            end
          end
        end
      end
      default: begin
        pkt_fifo_rd_en = !pkt_fifo_empty;
        if (!pkt_fifo_empty && pkt_fifo_ctrl != '0) begin
          pkt_dropped_d = 1'b1;
          stored_oq_d   = oq_q;
          state_d       = IDLE;
        end
      end
    endcase
    if (wr_word) begin
      mem_wr_en_d   = 1'b1;
      mem_wr_addr_d = {oq_q, ptr_all[oq_q]};
      mem_wr_data_d = {pkt_fifo_ctrl, pkt_fifo_data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      oq_q          <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      store_q       <= 1'b0;
      stored_oq_q   <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      pkt_stored_q  <= 1'b0;
      pkt_dropped_q <= 1'b0;
      len_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      oq_q          <= oq_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      store_q       <= store_d;
      stored_oq_q   <= stored_oq_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      pkt_stored_q  <= pkt_stored_d;
      pkt_dropped_q <= pkt_dropped_d;
      len_err_q     <= len_err_d;
    end
  end

  for (genvar g = 0; g < NUM_OUTPUT_QUEUES; g++) begin : g_lane
    logic [LW-1:0] add_len, sub_len, rel_len;
    logic          inc;
    assign add_len = (rsv && parsed_dst_oq == NUM_OQ_WIDTH'(g)) ? parsed_pkt_word_len : '0;
    assign sub_len = (rem_valid && rem_oq == NUM_OQ_WIDTH'(g)) ? rem_word_len : '0;
    assign rel_len = (oq_q == NUM_OQ_WIDTH'(g)) ? release_len : '0;
    assign inc     = wr_word && (oq_q == NUM_OQ_WIDTH'(g));
    oq_occ_lane #(.OCC_W(QW), .AW(OQ_ADDR_WIDTH), .LW(LW), .CW(CW)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .add_len (add_len),
      .sub_len (sub_len),
      .rel_len (rel_len),
      .ptr_inc (inc),
      .occ     (occ_all[g]),
      .wr_ptr  (ptr_all[g])
    );
  end

  a_rem_le_occ: assert property (@(posedge clk) disable iff (!reset_n)
    rem_valid |-> (CW'(rem_word_len) <= CW'(occ_all[rem_oq])));

  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign pkt_stored  = pkt_stored_q;
  assign pkt_dropped = pkt_dropped_q;
  assign len_err     = len_err_q;
  assign stored_oq   = stored_oq_q;
endmodule

// File: tb/tb_oq_pkt_store_ctrl.sv
// Directed bench: packet table plus hand sequences for stall, same-cycle
// reserve/release and asynchronous reset abort.
module tb_oq_pkt_store_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dst_oq_avail = 1'b0, rd_dst_oq;
  logic [2:0]  parsed_dst_oq = '0;
  logic [7:0]  parsed_pkt_word_len = '0;
  logic        pkt_fifo_empty = 1'b1, pkt_fifo_rd_en;
  logic [7:0]  pkt_fifo_ctrl = '0;
  logic [63:0] pkt_fifo_data = '0;
  logic        mem_wr_en;
  logic [11:0] mem_wr_addr;
  logic [71:0] mem_wr_data;
  logic        rem_valid = 1'b0;
  logic [2:0]  rem_oq = '0;
  logic [7:0]  rem_word_len = '0;
  logic        pkt_stored, pkt_dropped, len_err;
  logic [2:0]  stored_oq;

  oq_pkt_store_ctrl dut (
    .clk(clk), .reset_n(reset_n), .dst_oq_avail(dst_oq_avail), .rd_dst_oq(rd_dst_oq),
    .parsed_dst_oq(parsed_dst_oq), .parsed_pkt_word_len(parsed_pkt_word_len),
    .pkt_fifo_empty(pkt_fifo_empty), .pkt_fifo_rd_en(pkt_fifo_rd_en),
    .pkt_fifo_ctrl(pkt_fifo_ctrl), .pkt_fifo_data(pkt_fifo_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .rem_valid(rem_valid), .rem_oq(rem_oq), .rem_word_len(rem_word_len),
    .pkt_stored(pkt_stored), .pkt_dropped(pkt_dropped), .len_err(len_err),
    .stored_oq(stored_oq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int oq; int len; int nh; int nw; int nwr; bit st; bit err; int base; int rel; int occ;
  } vec_t;

  vec_t        tv[15];
  logic [10:0] dq[$];
  logic [71:0] pq[$];
  logic [11:0] wa[$];
  logic [71:0] wd[$];
  int n_stored = 0, n_dropped = 0, n_err = 0, n_st_wr = 0;
  logic [2:0] last_oq = '0;
  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    dst_oq_avail = (dq.size() != 0);
    if (dq.size() != 0) {parsed_dst_oq, parsed_pkt_word_len} = dq[0];
    pkt_fifo_empty = (pq.size() == 0);
    if (pq.size() != 0) {pkt_fifo_ctrl, pkt_fifo_data} = pq[0];
  endtask

  task automatic clr_mon();
    wa.delete(); wd.delete();
    n_stored = 0; n_dropped = 0; n_err = 0; n_st_wr = 0;
  endtask

  function automatic logic [71:0] word(input int tag, input int k, input int nw);
    logic [7:0] c;
    c = (k == nw - 1) ? 8'h01 : 8'h00;
    return {c, 16'(tag), 48'(k)};
  endfunction

  task automatic push_pkt(input int tag, input int nh, input int k0, input int k1, input int nw);
    for (int h = 0; h < nh; h++) pq.push_back({8'hFF, 64'hFFFF_0000_0000_0000 | 64'(h)});
    for (int k = k0; k < k1; k++) pq.push_back(word(tag, k, nw));
    drive();
  endtask

  task automatic wait_pulse(input string name);
    int t = 0;
    while (n_stored + n_dropped == 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 3000) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no pulse expected pulse within 3000 cycles", name);
    end
  endtask

  task automatic chk_writes(input string name, input int tag, input int base, input int nwr, input int nw);
    int bad = 0;
    int ea;
    chk({name, "_nwr"}, 128'(wa.size()), 128'(nwr));
    for (int i = 0; i < nwr && i < wa.size(); i++) begin
      ea = (base & 'hE00) | ((base + i) & 'h1FF);
      if (int'(wa[i]) != ea || wd[i] !== word(tag, i, nw)) bad++;
    end
    chk({name, "_addr_data"}, 128'(bad), 128'(0));
  endtask

  // Descriptor FIFO, packet FIFO and output monitor: pops are sampled at the
  // active edge, applied at the falling edge, outputs recorded there too.
  initial begin
    logic pp, pd;
    forever begin
      @(posedge clk);
      pp = pkt_fifo_rd_en;
      pd = rd_dst_oq;
      @(negedge clk);
      if (pp && pq.size() > 0) pq.delete(0);
      if (pd && dq.size() > 0) dq.delete(0);
      drive();
      if (mem_wr_en) begin
        wa.push_back(mem_wr_addr);
        wd.push_back(mem_wr_data);
      end
      if (pkt_stored) n_stored++;
      if (pkt_dropped) n_dropped++;
      if (len_err) n_err++;
      if (pkt_stored && mem_wr_en) n_st_wr++;
      if (pkt_stored || pkt_dropped) last_oq = stored_oq;
    end
  end

  initial begin
    int s;
    tv[0]  = '{2, 4,   1, 4,   4,   1, 0, 'h400, 0,   4};
    tv[1]  = '{1, 255, 1, 255, 255, 1, 0, 'h200, 255, 0};
    tv[2]  = '{1, 255, 0, 255, 255, 1, 0, 'h2FF, 255, 0};
    tv[3]  = '{1, 4,   1, 4,   4,   1, 0, 'h3FE, 0,   4};
    tv[4]  = '{1, 2,   0, 2,   2,   1, 0, 'h202, 0,   6};
    tv[5]  = '{0, 255, 1, 255, 255, 1, 0, 'h000, 0,   255};
    tv[6]  = '{0, 255, 1, 255, 255, 1, 0, 'h0FF, 0,   510};
    tv[7]  = '{0, 3,   1, 3,   0,   0, 0, 'h000, 0,   510};
    tv[8]  = '{0, 2,   1, 2,   2,   1, 0, 'h1FE, 0,   512};
    tv[9]  = '{0, 1,   1, 2,   0,   0, 0, 'h000, 0,   512};
    tv[10] = '{4, 5,   1, 3,   3,   1, 1, 'h800, 0,   3};
    tv[11] = '{4, 2,   1, 4,   2,   1, 1, 'h803, 0,   5};
    tv[12] = '{5, 0,   1, 2,   0,   0, 0, 'h000, 0,   0};
    tv[13] = '{6, 3,   2, 3,   3,   1, 0, 'hC00, 0,   3};
    tv[14] = '{3, 6,   1, 6,   6,   1, 0, 'h600, 0,   6};

    drive();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", 128'({rd_dst_oq, pkt_fifo_rd_en, mem_wr_en, mem_wr_addr, mem_wr_data,
                          pkt_stored, pkt_dropped, len_err, stored_oq}), 128'(0));
    s = 0;
    for (int q = 0; q < 8; q++) s += int'(dut.occ_all[q]);
    chk("rst_occ", 128'(s), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 15; v++) begin
      string nm;
      nm = $sformatf("v%0d", v);
      clr_mon();
      @(negedge clk);
      dq.push_back({3'(tv[v].oq), 8'(tv[v].len)});
      push_pkt(v, tv[v].nh, 0, tv[v].nw, tv[v].nw);
      wait_pulse(nm);
      chk_writes(nm, v, tv[v].base, tv[v].nwr, tv[v].nw);
      chk({nm, "_stored"}, 128'(n_stored), 128'(tv[v].st));
      chk({nm, "_dropped"}, 128'(n_dropped), 128'(!tv[v].st));
      chk({nm, "_len_err"}, 128'(n_err), 128'(tv[v].err));
      chk({nm, "_stored_oq"}, 128'(last_oq), 128'(tv[v].oq));
      chk({nm, "_eop_wr"}, 128'(n_st_wr), 128'(tv[v].st && tv[v].nwr == tv[v].nw));
      if (tv[v].rel != 0) begin
        @(negedge clk);
        rem_valid = 1'b1; rem_oq = 3'(tv[v].oq); rem_word_len = 8'(tv[v].rel);
        @(negedge clk);
        rem_valid = 1'b0;
      end
      @(negedge clk);
      chk({nm, "_occ"}, 128'(dut.occ_all[tv[v].oq]), 128'(tv[v].occ));
    end

    // Same-cycle reserve and release on queue 3, then a packet stalled by an empty FIFO.
    clr_mon();
    @(negedge clk);
    dq.push_back({3'd3, 8'd6});
    rem_valid = 1'b1; rem_oq = 3'd3; rem_word_len = 8'd6;
    drive();
    @(negedge clk);
    rem_valid = 1'b0;
    #1;
    chk("simul_occ", 128'(dut.occ_all[3]), 128'(6));
    dq.push_back({3'd7, 8'd2});
    drive();
    repeat (4) @(negedge clk);
    #1;
    chk("desc_wait", 128'(dq.size()), 128'(1));
    chk("stall_nowr", 128'(wa.size() + n_stored + n_dropped), 128'(0));
    push_pkt(20, 1, 0, 3, 6);
    repeat (6) @(negedge clk);
    #1;
    chk("stall_mid_nwr", 128'(wa.size()), 128'(3));
    chk("stall_mid_nopulse", 128'(n_stored + n_dropped), 128'(0));
    chk("stall_desc_held", 128'(dq.size()), 128'(1));
    push_pkt(20, 0, 3, 6, 6);
    wait_pulse("stall");
    chk_writes("stall", 20, 'h606, 6, 6);
    chk("stall_stored_oq", 128'({n_stored[3:0], last_oq}), 128'({4'd1, 3'd3}));
    clr_mon();
    @(negedge clk);
    push_pkt(21, 1, 0, 2, 2);
    wait_pulse("q7");
    chk_writes("q7", 21, 'hE00, 2, 2);
    chk("q7_stored_oq", 128'({n_stored[3:0], last_oq}), 128'({4'd1, 3'd7}));

    // Asynchronous reset in the middle of a stored packet.
    clr_mon();
    @(negedge clk);
    dq.push_back({3'd2, 8'd8});
    push_pkt(30, 1, 0, 8, 8);
    s = 0;
    while (wa.size() < 2 && s < 100) begin
      @(posedge clk);
      s++;
    end
    #2;
    chk("pre_rst_wr", 128'(mem_wr_en), 128'(1));
    reset_n = 1'b0;
    dq.delete(); pq.delete();
    drive();
    #1;
    chk("midrst_outs", 128'({rd_dst_oq, pkt_fifo_rd_en, mem_wr_en, mem_wr_addr, mem_wr_data,
                             pkt_stored, pkt_dropped, len_err, stored_oq}), 128'(0));
    chk("midrst_occ", 128'(dut.occ_all[2]), 128'(0));
    repeat (2) @(negedge clk);
    chk("midrst_nopulse", 128'(n_stored + n_dropped + n_err), 128'(0));
    reset_n = 1'b1;
    clr_mon();
    @(negedge clk);
    dq.push_back({3'd2, 8'd3});
    push_pkt(31, 0, 0, 3, 3);
    wait_pulse("post_rst");
    chk_writes("post_rst", 31, 'h400, 3, 3);
    chk("post_rst_stored", 128'(n_stored), 128'(1));
    @(negedge clk);
    chk("post_rst_occ", 128'(dut.occ_all[2]), 128'(3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/oq_pkt_store_ctrl.md
Name: oq_pkt_store_ctrl

Overview:
- Downstream consumer of the output-queue header parser's descriptor FIFO: dst_oq_avail, rd_dst_oq, parsed_dst_oq and parsed_pkt_word_len.
- Pops one descriptor per packet and reserves space in the destination queue's region of the shared packet memory.
- Streams that packet's data words from the parallel fall-through packet FIFO into the memory, or drops the packet if the queue lacks room.
- Tracks per-queue occupancy and write pointers; the remove side frees space.

Parameters:
- DATA_WIDTH, 64, packet data width.
- CTRL_WIDTH, DATA_WIDTH/8, control width.
- NUM_OUTPUT_QUEUES, 8, number of queues.
- NUM_OQ_WIDTH, 3, log2(NUM_OUTPUT_QUEUES).
- PKT_WORD_CNT_WIDTH, 8, descriptor word-length width.
- OQ_ADDR_WIDTH, 9, words per queue region = 2**OQ_ADDR_WIDTH.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- dst_oq_avail  in  1  descriptor FIFO non-empty.
- rd_dst_oq  out  1  descriptor pop.
- parsed_dst_oq  in  NUM_OQ_WIDTH  destination queue.
- parsed_pkt_word_len  in  PKT_WORD_CNT_WIDTH  data words in packet.
- pkt_fifo_empty  in  1  packet FIFO empty.
- pkt_fifo_rd_en  out  1  packet FIFO pop.
- pkt_fifo_ctrl  in  CTRL_WIDTH  fall-through control word.
- pkt_fifo_data  in  DATA_WIDTH  fall-through data word.
- mem_wr_en  out  1  memory write strobe.
- mem_wr_addr  out  NUM_OQ_WIDTH+OQ_ADDR_WIDTH  {queue, offset}.
- mem_wr_data  out  CTRL_WIDTH+DATA_WIDTH  {ctrl, data}.
- rem_valid  in  1  remover freed a packet.
- rem_oq  in  NUM_OQ_WIDTH  queue freed.
- rem_word_len  in  PKT_WORD_CNT_WIDTH  words freed.
- pkt_stored  out  1  pulse: packet committed.
- pkt_dropped  out  1  pulse: packet discarded.
- len_err  out  1  pulse: EOP not at descriptor length.
- stored_oq  out  NUM_OQ_WIDTH  queue for pkt_stored/pkt_dropped.

Behaviour:
- Reset: all registered outputs 0; states IDLE; all wr_ptr and occ cleared.
- Per queue q: occ[q] is OQ_ADDR_WIDTH+1 bits; free[q] = 2**OQ_ADDR_WIDTH - occ[q]; wr_ptr[q] is OQ_ADDR_WIDTH bits and wraps modulo region size.
- IDLE: when dst_oq_avail, assert rd_dst_oq for exactly 1 cycle and latch oq/len.
  - Store decision: store = (len != 0) && (len <= free[oq]).
  - If store, occ[oq] += len in that cycle (reservation).
  - Next state HDR.
- HDR: pkt_fifo_rd_en = !pkt_fifo_empty.
  - Popped words with ctrl != 0 are module headers: discarded, never written.
  - First ctrl == 0 word goes to STORE if store, else DROP. That word is written (STORE) or discarded (DROP) in the same pop.
- STORE: pkt_fifo_rd_en = !pkt_fifo_empty.
  - Each pop writes {ctrl,data} to {oq, wr_ptr[oq]}; wr_ptr[oq]++.
  - Write outputs are registered: mem_wr_* valid the cycle after the pop.
  - Count written words. The EOP word (ctrl != 0) is written.
  - At EOP: pkt_stored pulses with the EOP's mem_wr_en; stored_oq = oq; next state IDLE.
  - If EOP count != len, also pulse len_err:
    - count > len: words beyond len are popped but not written.
    - count < len: occ[oq] -= (len - count) at EOP.
- DROP: pop until EOP without writing; pulse pkt_dropped one cycle after the EOP pop; next state IDLE. len == 0 always drops.
- rem_valid: occ[rem_oq] -= rem_word_len in the same cycle.
  - Simultaneous reserve/release on the same queue: net update, occ + len - rem_word_len.
  - Remover never frees more than occ (checked by simulation assertion).
- Descriptor pop and packet streaming never overlap: at most one packet in flight, one pop per cycle max.
- Empty packet FIFO mid-packet: stall in place, no write, no state change.
- reset_n low mid-packet: immediate abort. No pulses, occupancy cleared. Upstream FIFOs are reset concurrently.

Test Plan:
- Desc oq=2,len=4; one header word then 4 data words, last ctrl=0x01 -> writes at 0x400..0x403; pkt_stored, stored_oq=2; occ[2]=4.
- oq=1, wr_ptr=510, len=4 -> addresses 0x3FE,0x3FF,0x200,0x201 (wrap); wr_ptr[1]=2.
- occ[0]=510, desc oq=0 len=3 -> no mem_wr_en; pkt_dropped, stored_oq=0; occ[0] unchanged.
- Desc len=5 but EOP on word 3 -> 3 writes, len_err; occ reflects 3. Then desc len=2 with 4 words -> 2 writes, len_err.
- Reserve oq=3 len=6 in the same cycle as rem_valid oq=3 len=6 with occ=6 -> occ[3]=6. Descriptor waits while pkt_fifo_empty stalls mid-packet; no spurious writes.
- reset_n low mid-STORE -> all outputs 0 asynchronously. Next packet to the same queue writes at offset 0.
